// File: rtl/bp_be_accel_ws_xor_core_if.sv
// Load/stream handshake bundle for the weight-stationary XOR accelerator core.
interface bp_be_accel_ws_xor_core_if #(
    parameter int unsigned block_width_p = 512,
    parameter int unsigned fill_width_p  = 128
);
    logic [1:0]               op_i;
    logic [block_width_p-1:0] data_i;
    logic                     v_i;
    logic                     ready_o;
    logic [fill_width_p-1:0]  data_o;
    logic                     v_o;
    logic                     yumi_i;
    logic                     error_o;

    modport slave (
        input  op_i, data_i, v_i, yumi_i,
        output ready_o, data_o, v_o, error_o
    );

    modport master (
        output op_i, data_i, v_i, yumi_i,
        input  ready_o, data_o, v_o, error_o
    );
endinterface

// File: rtl/bp_be_accel_ws_xor_core.sv
// Weight-stationary XOR core: two act/weight slot pairs, result = act ^ wt,
// streamed out LSB beat first in fill_width_p chunks.
module bp_be_accel_ws_xor_core #(
    parameter int unsigned block_width_p = 512,
    parameter int unsigned fill_width_p  = 128
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    bp_be_accel_ws_xor_core_if.slave  io
);
    localparam int unsigned beats_lp = block_width_p / fill_width_p;
    localparam int unsigned cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

    localparam logic [0:0] idle_s = 1'b0;
    localparam logic [0:0] send_s = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
    logic [1:0]               act_v_q, act_v_d;
    logic [1:0]               wt_v_q, wt_v_d;
    logic                     error_q, error_d;
    logic [block_width_p-1:0] act_q [2];
    logic [block_width_p-1:0] act_d [2];
    logic [block_width_p-1:0] wt_q [2];
    logic [block_width_p-1:0] wt_d [2];
    logic [block_width_p-1:0] result_q, result_d;

    logic       ready_c;
    logic [1:0] armed_c;
    logic       slot_c;

    // An activation may only land in an empty act register; weights always overwrite.
    assign ready_c = ~(~io.op_i[1] & act_v_q[io.op_i[0]]);
    assign armed_c = act_v_q & wt_v_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        act_v_d  = act_v_q;
        wt_v_d   = wt_v_q;
        error_d  = error_q;
        result_d = result_q;
        act_d    = act_q;
        wt_d     = wt_q;
        slot_c   = 1'b0;

        case (state_q)
            idle_s: begin
                if (|armed_c) begin
                    slot_c           = ~armed_c[0];
                    result_d         = act_q[slot_c] ^ wt_q[slot_c];
                    act_v_d[slot_c]  = 1'b0;
                    cnt_d            = '0;
                    state_d          = send_s;
                end
            end
            send_s: begin
                if (io.yumi_i) begin
                    if (cnt_q == cnt_w_lp'(beats_lp - 1)) begin
                        cnt_d   = '0;
                        state_d = idle_s;
                    end else begin
                        cnt_d = cnt_q + cnt_w_lp'(1);
                    end
                end
            end
            default: state_d = idle_s;
        endcase

        // Loads apply after capture so a same-cycle weight write only affects later blocks.
        if (io.v_i) begin
            if (ready_c) begin
                if (io.op_i[1]) begin
                    wt_d[io.op_i[0]]   = io.data_i;
                    wt_v_d[io.op_i[0]] = 1'b1;
                end else begin
                    act_d[io.op_i[0]]   = io.data_i;
                    act_v_d[io.op_i[0]] = 1'b1;
                end
            end else begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= idle_s;
            cnt_q   <= '0;
            act_v_q <= '0;
            wt_v_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_v_q <= act_v_d;
            wt_v_q  <= wt_v_d;
            error_q <= error_d;
        end
    end

    // Payload registers carry no reset; their valid bits gate every use.
    always_ff @(posedge clk_i) begin
        act_q    <= act_d;
        wt_q     <= wt_d;
        result_q <= result_d;
    end

    assign io.ready_o = ready_c;
    assign io.v_o     = (state_q == send_s);
    assign io.data_o  = result_q[32'(cnt_q) * fill_width_p +: fill_width_p];
    assign io.error_o = error_q;

endmodule

// File: doc/bp_be_accel_ws_xor_core.md
BP_BE_ACCEL_WS_XOR_CORE -- requirements
Module: bp_be_accel_ws_xor_core

Interface
REQ-001 SHALL have parameter block_width_p, default 512, the wide load width in bits (one dcache block).
REQ-002 SHALL have parameter fill_width_p, default 128, the output beat width in bits; block_width_p SHALL be an integer multiple of fill_width_p (beats_lp = block_width_p/fill_width_p, default 4).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port op_i  input  2  load target: 00 ACLD0, 01 ACLD1, 10 WTLD0, 11 WTLD1.
REQ-006 SHALL have port data_i  input  block_width_p  wide load data.
REQ-007 SHALL have port v_i  input  1  load valid; a load is accepted when v_i & ready_o.
REQ-008 SHALL have port ready_o  output  1  load can be accepted (combinational on op_i and state).
REQ-009 SHALL have port data_o  output  fill_width_p  current result beat.
REQ-010 SHALL have port v_o  output  1  data_o valid.
REQ-011 SHALL have port yumi_i  input  1  consumer takes the beat; legal only when v_o=1.
REQ-012 SHALL have port error_o  output  1  sticky overrun flag.

Function
REQ-013 SHALL hold four block registers act0, act1, wt0, wt1, each with a valid bit.
REQ-014 SHALL write data_i into the op_i-selected register and set its valid on an accepted load.
REQ-015 SHALL drive ready_o=0 when op_i selects ACLDk and act_k valid is 1; otherwise ready_o=1. WTLD loads are always accepted and overwrite the weight.
REQ-016 SHALL consider slot k armed when act_k valid & wt_k valid; slot 0 has priority if both are armed.
REQ-017 SHALL implement FSM states IDLE and SEND; reset state IDLE.
REQ-018 In IDLE with an armed slot k, SHALL register result = act_k XOR wt_k, clear act_k valid (wt_k valid unchanged: weights stationary), zero the beat counter, and enter SEND.
REQ-019 In SEND, SHALL drive v_o=1 and data_o = result[cnt*fill_width_p +: fill_width_p] (LSB beat first).
REQ-020 In SEND, SHALL increment cnt on yumi_i; on yumi_i with cnt = beats_lp-1, SHALL return to IDLE with cnt=0.
REQ-021 Latency: a load accepted at edge t that arms a slot while in IDLE SHALL yield v_o=1 after edge t+1; back-to-back blocks SHALL have one IDLE cycle between them.
REQ-022 Loads SHALL be accepted in any FSM state, including during SEND.
REQ-023 A WTLDk accepted in the same cycle that slot k is captured SHALL not affect the captured result; the new weight SHALL be stored.
REQ-024 An ACLDk presented in the capture cycle of slot k SHALL see ready_o=0 (pre-capture valid) and be rejected.
REQ-025 v_i & ~ready_o SHALL drop the load, leave all registers unchanged, and set error_o; error_o SHALL clear only on reset.
REQ-026 v_o SHALL be 0 in IDLE; data_o SHALL be don't-care when v_o=0.

Reset
REQ-027 Asserting reset_i SHALL immediately clear all four valid bits, cnt, error_o, v_o, and force IDLE, including mid-SEND; data registers need not be reset.
REQ-028 After reset deassertion, ready_o SHALL be 1 for every op_i.

Verification
REQ-029 WTLD0 D=all 0xF0 bytes, then ACLD0 D=all 0xFF bytes, yumi_i held 1 -> v_o rises the cycle after ACLD0 accept, 4 beats of 128'h0F..0F, then v_o=0.
REQ-030 Weight reuse: after REQ-029, ACLD0 with 0x00 bytes -> 4 beats of 0xF0 bytes without reloading WTLD0.
REQ-031 ACLD0 and ACLD1 loaded with both weights valid -> slot 0 block fully streamed before slot 1 block; yumi_i toggling 1/0 -> beats in order, none duplicated.
REQ-032 ACLD0 twice with WT0 invalid -> ready_o=0 on second, error_o=1 and stays 1; act0 keeps first data.
REQ-033 Assert reset_i after beat 2 of a stream -> v_o=0 immediately, error_o=0, ready_o=1; new WT/ACT pair streams from beat 0.
REQ-034 WTLD0 new value in the capture cycle of slot 0 -> streamed result uses old weight; next ACLD0 uses new weight.
